// File: rtl/vga_syncgen_pkg.sv
// Shared raster timing defaults and FSM encoding for the VGA sync generator
// and the pattern generator downstream of it.
`timescale 1ns/1ps
package vga_syncgen_pkg;
  localparam int CNT_W = 10;
  localparam int FC_W  = 16;

  // 640x480 @ 60 Hz with a 25.175 MHz pixel clock
  localparam int DEF_H_SYNC_INTERVAL = 800;
  localparam int DEF_H_FRONT         = 16;
  localparam int DEF_H_PULSE_WIDTH   = 96;
  localparam int DEF_H_BRANK         = 160;
  localparam int DEF_V_SYNC_INTERVAL = 525;
  localparam int DEF_V_FRONT         = 10;
  localparam int DEF_V_PULSE_WIDTH   = 2;
  localparam int DEF_V_BRANK         = 45;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_e;
endpackage

// File: rtl/vga_syncgen_if.sv
// Run request in, raster counters and delayed sync/enable strobes out.
`timescale 1ns/1ps
interface vga_syncgen_if;
  import vga_syncgen_pkg::*;

  logic             EN;
  logic [CNT_W-1:0] HCNT;
  logic [CNT_W-1:0] VCNT;
  logic             VGA_HS;
  logic             VGA_VS;
  logic             VGA_DE;
  logic             FRAME_START;
  logic [FC_W-1:0]  FRAME_CNT;
  logic             RUNNING;

  modport slave (
    input  EN,
    output HCNT, VCNT, VGA_HS, VGA_VS, VGA_DE, FRAME_START, FRAME_CNT, RUNNING
  );

  modport master (
    output EN,
    input  HCNT, VCNT, VGA_HS, VGA_VS, VGA_DE, FRAME_START, FRAME_CNT, RUNNING
  );
endinterface

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrap counter with clear, plus sync-window and active-window
// decode of the current count.
`timescale 1ns/1ps
module vga_axis_cnt
  import vga_syncgen_pkg::*;
#(
  parameter int LIMIT      = DEF_H_SYNC_INTERVAL,
  parameter int SYNC_START = DEF_H_FRONT,
  parameter int SYNC_WIDTH = DEF_H_PULSE_WIDTH,
  parameter int ACT_START  = DEF_H_BRANK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             sync_o,
  output logic             act_o
);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(SYNC_START + SYNC_WIDTH);
  localparam logic [CNT_W-1:0] ACT_LO  = CNT_W'(ACT_START);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wrap_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign sync_o = (cnt_q >= SYNC_LO) && (cnt_q < SYNC_HI);
  assign act_o  = (cnt_q >= ACT_LO);
endmodule

// File: rtl/vga_syncgen.sv
// VGA raster timing generator: run/stop FSM that only halts on a frame
// boundary, H/V counters, and sync/enable strobes registered one cycle late.
`timescale 1ns/1ps
module vga_syncgen
  import vga_syncgen_pkg::*;
#(
  parameter int H_SYNC_INTERVAL = DEF_H_SYNC_INTERVAL,
  parameter int H_FRONT         = DEF_H_FRONT,
  parameter int H_PULSE_WIDTH   = DEF_H_PULSE_WIDTH,
  parameter int H_BRANK         = DEF_H_BRANK,
  parameter int V_SYNC_INTERVAL = DEF_V_SYNC_INTERVAL,
  parameter int V_FRONT         = DEF_V_FRONT,
  parameter int V_PULSE_WIDTH   = DEF_V_PULSE_WIDTH,
  parameter int V_BRANK         = DEF_V_BRANK
) (
  input  logic         PCK,
  input  logic         RST,
  vga_syncgen_if.slave bus
);
  state_e           state_q, state_d;
  logic             run_w, last_px;
  logic [CNT_W-1:0] hcnt, vcnt;
  logic             h_wrap, v_wrap, h_sync, v_sync, h_act, v_act;
  logic             hs_q, vs_q, de_q, fs_q;
  logic             hs_d, vs_d, de_d, fs_d;
  logic [FC_W-1:0]  fc_q, fc_d;

  assign run_w   = (state_q != IDLE);
  assign last_px = h_wrap && v_wrap;

  // Counters sit at zero while idle; the vertical axis steps on the horizontal wrap
  vga_axis_cnt #(
    .LIMIT(H_SYNC_INTERVAL), .SYNC_START(H_FRONT),
    .SYNC_WIDTH(H_PULSE_WIDTH), .ACT_START(H_BRANK)
  ) u_hcnt (
    .clk(PCK), .rst(RST), .en_i(run_w), .clr_i(!run_w),
    .cnt_o(hcnt), .wrap_o(h_wrap), .sync_o(h_sync), .act_o(h_act)
  );

  vga_axis_cnt #(
    .LIMIT(V_SYNC_INTERVAL), .SYNC_START(V_FRONT),
    .SYNC_WIDTH(V_PULSE_WIDTH), .ACT_START(V_BRANK)
  ) u_vcnt (
    .clk(PCK), .rst(RST), .en_i(run_w && h_wrap), .clr_i(!run_w),
    .cnt_o(vcnt), .wrap_o(v_wrap), .sync_o(v_sync), .act_o(v_act)
  );

  always_ff @(posedge PCK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A stop request is only honoured on the last pixel of a frame
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (bus.EN) state_d = RUN;
      RUN:       if (!bus.EN) state_d = STOP_PEND;
      STOP_PEND: begin
        if (bus.EN) begin
          state_d = RUN;
        end else if (last_px) begin
          state_d = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    hs_d = !(run_w && h_sync);
    vs_d = !(run_w && v_sync);
    de_d = run_w && h_act && v_act;
    fs_d = run_w && (hcnt == '0) && (vcnt == '0);
    fc_d = fs_d ? fc_q + 1'b1 : fc_q;
  end

  // Strobes lag the counters by one cycle to line up with registered RGB
  always_ff @(posedge PCK or posedge RST) begin
    if (RST) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      de_q <= 1'b0;
      fs_q <= 1'b0;
      fc_q <= '0;
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      fs_q <= fs_d;
      fc_q <= fc_d;
    end
  end

  assign bus.HCNT        = hcnt;
  assign bus.VCNT        = vcnt;
  assign bus.VGA_HS      = hs_q;
  assign bus.VGA_VS      = vs_q;
  assign bus.VGA_DE      = de_q;
  assign bus.FRAME_START = fs_q;
  assign bus.FRAME_CNT   = fc_q;
  assign bus.RUNNING     = run_w;
endmodule

// File: tb/tb_vga_syncgen.sv
// Bench for vga_syncgen on a reduced 40x20 raster so whole frames stay short.
`timescale 1ns/1ps
module tb_vga_syncgen;
  localparam int HT = 40;
  localparam int HF = 4;
  localparam int HP = 6;
  localparam int HB = 16;
  localparam int VT = 20;
  localparam int VF = 2;
  localparam int VP = 2;
  localparam int VB = 6;

  logic PCK = 1'b0;
  logic RST = 1'b0;

  vga_syncgen_if bus();

  vga_syncgen #(
    .H_SYNC_INTERVAL(HT), .H_FRONT(HF), .H_PULSE_WIDTH(HP), .H_BRANK(HB),
    .V_SYNC_INTERVAL(VT), .V_FRONT(VF), .V_PULSE_WIDTH(VP), .V_BRANK(VB)
  ) dut (
    .PCK(PCK),
    .RST(RST),
    .bus(bus)
  );

  always #5 PCK = ~PCK;

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [15:0] fc;
    logic        run;
  } obs_t;

  typedef struct {
    int          n;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [15:0] fc;
  } vec_t;

  obs_t sb_q[$];
  obs_t last_a;
  obs_t prev_a;
  int   total = 0;
  int   bad   = 0;
  int   m_st, m_h, m_v, m_fc;
  int   prev_h, prev_v;
  int   fs_seen, hs_low, vs_low, de_hi;

  function automatic obs_t sample();
    obs_t o;
    o.h   = bus.HCNT;
    o.v   = bus.VCNT;
    o.hs  = bus.VGA_HS;
    o.vs  = bus.VGA_VS;
    o.de  = bus.VGA_DE;
    o.fs  = bus.FRAME_START;
    o.fc  = bus.FRAME_CNT;
    o.run = bus.RUNNING;
    return o;
  endfunction

  function automatic obs_t rst_obs();
    obs_t o;
    o.h = '0; o.v = '0; o.hs = 1'b1; o.vs = 1'b1;
    o.de = 1'b0; o.fs = 1'b0; o.fc = '0; o.run = 1'b0;
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_h = 0; m_v = 0; m_fc = 0;
    prev_h = 0; prev_v = 0;
    sb_q.delete();
  endtask

  // Behavioural reference: what the outputs must read after the coming edge
  task automatic model_step(input logic en, output obs_t e);
    bit r, last;
    r    = (m_st != 0);
    last = (m_h == HT - 1) && (m_v == VT - 1);
    e.hs = !(r && (m_h >= HF) && (m_h < HF + HP));
    e.vs = !(r && (m_v >= VF) && (m_v < VF + VP));
    e.de = r && (m_h >= HB) && (m_v >= VB);
    e.fs = r && (m_h == 0) && (m_v == 0);
    if (e.fs) m_fc = (m_fc + 1) % 65536;
    if (r) begin
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
    case (m_st)
      0: if (en) m_st = 1;
      1: if (!en) m_st = 2;
      2: if (en) m_st = 1; else if (last) m_st = 0;
      default: m_st = 0;
    endcase
    e.h   = 10'(m_h);
    e.v   = 10'(m_v);
    e.fc  = 16'(m_fc);
    e.run = (m_st != 0);
  endtask

  task automatic step(input logic en);
    obs_t e, a;
    bus.EN = en;
    model_step(en, e);
    sb_q.push_back(e);
    @(posedge PCK);
    #1;
    prev_a = last_a;
    a      = sample();
    last_a = a;
    e      = sb_q.pop_front();
    chk("cycle", 64'(a), 64'(e));
    if (a.fs) fs_seen++;
    if (!a.hs) hs_low++;
    if (!a.vs) vs_low++;
    if (a.de) de_hi++;
    if (int'(a.v) != prev_v) begin
      chk("vstep", {44'd0, a.h, 10'(prev_h)}, {44'd0, 10'd0, 10'(HT - 1)});
    end
    prev_h = int'(a.h);
    prev_v = int'(a.v);
  endtask

  initial begin
    vec_t tbl[12];
    int   n, per, fc_snap, guard;

    tbl[0]  = '{1,   10'd1,  10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1};
    tbl[1]  = '{2,   10'd2,  10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[2]  = '{5,   10'd5,  10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[3]  = '{10,  10'd10, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[4]  = '{11,  10'd11, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[5]  = '{81,  10'd1,  10'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[6]  = '{141, 10'd21, 10'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[7]  = '{161, 10'd1,  10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[8]  = '{256, 10'd16, 10'd6, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[9]  = '{257, 10'd17, 10'd6, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1};
    tbl[10] = '{800, 10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1};
    tbl[11] = '{801, 10'd1,  10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2};

    bus.EN = 1'b0;
    model_reset();
    last_a = rst_obs();
    #1 RST = 1'b1;
    #2;
    chk("reset_state", 64'(sample()), 64'(rst_obs()));
    @(negedge PCK);
    RST = 1'b0;

    // Idle with EN low
    fs_seen = 0;
    repeat (100) step(1'b0);
    chk("idle_fs", 64'(fs_seen), 64'(0));
    chk("idle_outs", {40'd0, last_a.h, last_a.v, last_a.hs, last_a.vs, last_a.de, last_a.run},
        {40'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0});

    // Start and table of raster positions relative to the RUN edge
    step(1'b1);
    chk("start_run", {44'd0, last_a.run, last_a.h, last_a.v, last_a.fs}, {44'd0, 1'b1, 10'd0, 10'd0, 1'b0});
    n = 0;
    for (int i = 0; i < 12; i++) begin
      while (n < tbl[i].n) begin
        step(1'b1);
        n++;
      end
      chk($sformatf("vec%0d", tbl[i].n),
          {24'd0, last_a.h, last_a.v, last_a.hs, last_a.vs, last_a.de, last_a.fs, last_a.fc},
          {24'd0, tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs, tbl[i].de, tbl[i].fs, tbl[i].fc});
    end

    // One whole frame between FRAME_START pulses
    hs_low = 0; vs_low = 0; de_hi = 0; fs_seen = 0; per = 0;
    guard = 0;
    do begin
      step(1'b1);
      per++;
      guard++;
    end while (!last_a.fs && guard < 2000);
    chk("frame_period", 64'(per), 64'(HT * VT));
    chk("frame_de", 64'(de_hi), 64'((HT - HB) * (VT - VB)));
    chk("frame_vs_low", 64'(vs_low), 64'(VP * HT));
    chk("frame_hs_low", 64'(hs_low), 64'(HP * VT));
    chk("frame_fs_count", 64'(fs_seen), 64'(1));
    chk("frame_cnt3", 64'(last_a.fc), 64'(3));

    // Stop request mid-frame: finish the frame, then idle
    guard = 0;
    while (last_a.v != 10'd8 && guard < 1000) begin
      step(1'b1);
      guard++;
    end
    fc_snap = int'(last_a.fc);
    fs_seen = 0;
    guard = 0;
    do begin
      step(1'b0);
      guard++;
    end while (last_a.run && guard < 2000);
    chk("stop_idle", {43'd0, last_a.h, last_a.v, last_a.run}, {43'd0, 10'd0, 10'd0, 1'b0});
    chk("stop_last_px", {44'd0, prev_a.h, prev_a.v}, {44'd0, 10'(HT - 1), 10'(VT - 1)});
    chk("stop_no_fs", 64'(fs_seen), 64'(0));
    chk("stop_fc", 64'(last_a.fc), 64'(fc_snap));
    repeat (50) step(1'b0);
    chk("stop_hold", {44'd0, last_a.h, last_a.v}, {44'd0, 10'd0, 10'd0});
    chk("stop_hold_fs", 64'(fs_seen), 64'(0));

    // EN dropped and re-raised inside one frame
    guard = 0;
    do begin
      step(1'b1);
      guard++;
    end while (last_a.v != 10'd4 && guard < 1000);
    fc_snap = int'(last_a.fc);
    guard = 0;
    do begin
      step(1'b0);
      guard++;
    end while (last_a.v != 10'd12 && guard < 1000);
    chk("toggle_running", 64'(last_a.run), 64'(1));
    guard = 0;
    do begin
      step(1'b1);
      guard++;
    end while (!last_a.fs && guard < 1000);
    chk("toggle_next_fs", {28'd0, last_a.h, last_a.v, last_a.fc}, {28'd0, 10'd1, 10'd0, 16'(fc_snap + 1)});

    // Asynchronous reset in the middle of a frame
    guard = 0;
    while (!(last_a.h == 10'd20 && last_a.v == 10'd12) && guard < 1000) begin
      step(1'b1);
      guard++;
    end
    chk("pre_rst_pos", {44'd0, last_a.h, last_a.v}, {44'd0, 10'd20, 10'd12});
    #1 RST = 1'b1;
    #1;
    chk("rst_async", 64'(sample()), 64'(rst_obs()));
    bus.EN = 1'b0;
    model_reset();
    last_a = rst_obs();
    @(negedge PCK);
    @(negedge PCK);
    RST = 1'b0;
    repeat (5) step(1'b0);
    chk("post_rst_idle", 64'(last_a), 64'(rst_obs()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
